pool2x2_stream_ctrl: RTL and testbench
======================================

Name: pool2x2_stream_ctrl

Overview:
- Scheduler that streams a row-major FP16 feature map through one internally instantiated pooling_2x2 datapath and emits the 2x2 max-pooled map.
- Sits between a conv-layer output stream and the next layer's input.
- Top-row pixel pairs go into a half-width line buffer. Each bottom-row pair is then sequenced through pooling_2x2 in two cycles: the buffered top pair with store=1, then the bottom pair with store=0.
- Valid/ready handshake on both sides.

Parameters:
- MAP_W, 24, input map width in pixels; must be even and >= 2.
- MAP_H, 24, input map height in pixels; must be even and >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input pair valid
- in_ready  out  1  input pair accepted when in_valid && in_ready
- in_a  in  16  FP16 left pixel of horizontally adjacent pair (even column)
- in_b  in  16  FP16 right pixel (odd column)
- out_valid  out  1  pooled output valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  16  FP16 pooled value
- out_last  out  1  high with the final pooled value of a frame
- frame_done  out  1  one-cycle pulse when the final output of a frame is handshaken
- busy  out  1  high when any counter is non-zero, in S_CMP, or out_valid is high

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high; every register updates on posedge clk only. rst also drives the rst pin of the pooling_2x2 instance.
- Compile-time check: elaboration error if MAP_W or MAP_H is odd or < 2.
- Reset values: state=S_TOP; col=0; rowpair=0; out_valid=0; out_data=16'h0000; out_last=0; frame_done=0. Line buffer and hold register are not cleared; their contents are don't-care.
- Counters:
  - col counts 0..MAP_W/2-1, one count per pair.
  - rowpair counts 0..MAP_H/2-1.
  - Line buffer: MAP_W/2 entries of 32 bits {a,b}, indexed by col. Combinational read.
- S_TOP:
  - in_ready=1. pool store=0.
  - On accept, write {in_a,in_b} to linebuf[col].
  - col wraps at MAP_W/2-1 to 0 and the state goes to S_BOT; otherwise col++.
- S_BOT:
  - in_ready=1. Pool a/b = linebuf[col].
  - pool store = accept (in_valid), so max_temp <= max(top pair) at the edge.
  - On accept, capture {in_a,in_b} into hold and go to S_CMP.
- S_CMP:
  - in_ready=0. Pool a/b = hold, store=0.
  - pooled_value = max(max(bottom pair), max_temp), combinational.
  - Output slot free = !out_valid || out_ready. When free: out_data<=pooled_value; out_valid<=1; out_last<=(col==MAP_W/2-1 && rowpair==MAP_H/2-1).
  - Then advance: col++ and go to S_BOT. At col wrap: col=0, rowpair++, go to S_TOP. At the last rowpair, rowpair wraps to 0 (frame complete, next frame starts immediately).
  - When the slot is not free, stay in S_CMP with all state held (stall).
- Output register:
  - Clears out_valid on out_ready when not reloaded in the same cycle.
  - Simultaneous drain and load in S_CMP is legal: zero bubble.
  - out_data/out_last hold stable while out_valid && !out_ready.
- frame_done: pulses in the cycle after a handshake with out_last=1.
- Latency: first output appears 1 cycle after the S_CMP entry for window (0,0). Output valid is registered.
- Throughput (no backpressure), per frame:
  - (MAP_H/2)*(MAP_W/2) cycles for top rows.
  - (MAP_H/2)*MAP_W cycles for bottom rows.
- Comparison semantics: entirely those of fp16_max_comparator; the controller does no arithmetic.
- in_valid gaps: states simply wait; no timeout.
- Reset mid-frame: the frame is aborted, any pending output is dropped (out_valid=0), and the next accepted pair is treated as row 0, column pair 0.

Test Plan:
1. MAP_W=4, MAP_H=4; feed 1.0..16.0 row-major (0x3C00,0x4000,...); out_ready=1 -> outputs 0x4600(6), 0x4800(8), 0x4B00(14), 0x4C00(16) in order; out_last only on 0x4C00; frame_done one cycle later.
2. MAP_W=2, MAP_H=2; pairs {-1.0,-2.0}=(0xBC00,0xC000), then {-3.0,-0.5}=(0xC200,0xB800) -> out_data=0xB800; repeat with the maximum in each of the four window positions -> correct max each time.
3. Test 1 with out_ready held low for 10 cycles after the first out_valid -> out_data stable at 0x4600; in_ready=0 while in S_CMP with the slot full; no outputs lost or duplicated once released.
4. Default 24x24, continuous in_valid and out_ready=1, random FP16 vs. golden model -> 144 outputs, last output at cycle 432 (+1 latency); in_ready low exactly on every second bottom-row cycle.
5. Assert rst for 1 cycle after 5 accepted beats of a 4x4 frame -> next cycle out_valid=0, in_ready=1, busy=0; a fresh full frame then yields the same 4 results as test 1.
6. Random in_valid gaps and random out_ready, two back-to-back frames -> output sequence matches the golden model; out_last/frame_done exactly once per frame.

Source files
------------

// File: rtl/pool2x2_stream_ctrl.sv
// 2x2 max-pooling stream controller: buffers top-row pixel pairs and sequences
// each bottom-row pair through a pooling_2x2 datapath to emit one FP16 max per window.

module fp16_max_comparator (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] max_c
);
  logic [15:0] key_a;
  logic [15:0] key_b;

  // Map sign-magnitude onto an unsigned total order (+0 ranks above -0).
  always_comb begin
    key_a = a_i[15] ? ~a_i : {1'b1, a_i[14:0]};
    key_b = b_i[15] ? ~b_i : {1'b1, b_i[14:0]};
    max_c = (key_a >= key_b) ? a_i : b_i;
  end
endmodule

module pooling_2x2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        store_i,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  output logic [15:0] pooled_c
);
  logic [15:0] pair_max;
  logic [15:0] max_temp_q;

  fp16_max_comparator u_cmp_pair (
    .a_i   (a_i),
    .b_i   (b_i),
    .max_c (pair_max)
  );

  fp16_max_comparator u_cmp_acc (
    .a_i   (pair_max),
    .b_i   (max_temp_q),
    .max_c (pooled_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      max_temp_q <= 16'h0000;
    end else if (store_i) begin
      max_temp_q <= pair_max;
    end
  end
endmodule

module pool2x2_stream_ctrl #(
  parameter int unsigned MAP_W = 24,
  parameter int unsigned MAP_H = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_last,
  output logic        frame_done,
  output logic        busy
);
  localparam int unsigned NPAIR = MAP_W / 2;
  localparam int unsigned NROWP = MAP_H / 2;
  localparam int unsigned COL_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam int unsigned ROW_W = (NROWP > 1) ? $clog2(NROWP) : 1;

  if ((MAP_W % 2) != 0 || MAP_W < 2 || (MAP_H % 2) != 0 || MAP_H < 2) begin : g_bad_map
    $error("pool2x2_stream_ctrl: MAP_W and MAP_H must be even and >= 2");
  end

  typedef enum logic [1:0] {
    S_TOP = 2'd0,
    S_BOT = 2'd1,
    S_CMP = 2'd2
  } state_t;

  state_t             state_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [31:0]        linebuf_q [NPAIR];
  logic [31:0]        hold_q;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [15:0]        out_data_q;
  logic               out_last_q;
  logic               frame_done_q;

  logic [31:0]        lb_rd;
  logic [15:0]        pool_a;
  logic [15:0]        pool_b;
  logic               pool_store;
  logic [15:0]        pool_c;
  logic               accept;
  logic               slot_free;
  logic               col_last;
  logic               row_last;

  assign lb_rd     = linebuf_q[col_q];
  assign accept    = in_valid && in_ready_q;
  assign slot_free = !out_valid_q || out_ready;
  assign col_last  = (col_q == COL_W'(NPAIR - 1));
  assign row_last  = (row_q == ROW_W'(NROWP - 1));

  // Datapath steering: buffered top pair while accepting the bottom pair, then the held bottom pair.
  always_comb begin
    pool_a     = hold_q[31:16];
    pool_b     = hold_q[15:0];
    pool_store = 1'b0;
    case (state_q)
      S_BOT: begin
        pool_a     = lb_rd[31:16];
        pool_b     = lb_rd[15:0];
        pool_store = accept;
      end
      default: begin
      end
    endcase
  end

  pooling_2x2 u_pool (
    .clk      (clk),
    .rst      (rst),
    .store_i  (pool_store),
    .a_i      (pool_a),
    .b_i      (pool_b),
    .pooled_c (pool_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_TOP;
      col_q        <= '0;
      row_q        <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= 16'h0000;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= out_valid_q && out_ready && out_last_q;
      if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_TOP: begin
          if (accept) begin
            linebuf_q[col_q] <= {in_a, in_b};
            if (col_last) begin
              col_q   <= '0;
              state_q <= S_BOT;
            end else begin
              col_q <= col_q + COL_W'(1);
            end
          end
        end
        S_BOT: begin
          if (accept) begin
            hold_q     <= {in_a, in_b};
            state_q    <= S_CMP;
            in_ready_q <= 1'b0;
          end
        end
        S_CMP: begin
          // Load may coincide with a drain of the previous value: no bubble.
          if (slot_free) begin
            out_valid_q <= 1'b1;
            out_data_q  <= pool_c;
            out_last_q  <= col_last && row_last;
            in_ready_q  <= 1'b1;
            if (col_last) begin
              col_q   <= '0;
              row_q   <= row_last ? '0 : row_q + ROW_W'(1);
              state_q <= S_TOP;
            end else begin
              col_q   <= col_q + COL_W'(1);
              state_q <= S_BOT;
            end
          end
        end
        default: begin
          state_q    <= S_TOP;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
  assign busy       = (col_q != '0) || (row_q != '0) || (state_q == S_CMP) || out_valid_q;

endmodule

// File: tb/tb_pool2x2_stream_ctrl.sv
// Bench for pool2x2_stream_ctrl: three instances (4x4, 2x2, 24x24) checked against a
// scoreboard of expected pooled values produced by an independent FP16 max model.

module tb_pool2x2_stream_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [3];
  logic        in_valid   [3];
  logic        in_ready   [3];
  logic [15:0] in_a       [3];
  logic [15:0] in_b       [3];
  logic        out_valid  [3];
  logic        out_ready  [3];
  logic [15:0] out_data   [3];
  logic        out_last   [3];
  logic        frame_done [3];
  logic        busy       [3];

  pool2x2_stream_ctrl #(.MAP_W(4), .MAP_H(4)) u_dut4 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_last(out_last[0]), .frame_done(frame_done[0]), .busy(busy[0])
  );

  pool2x2_stream_ctrl #(.MAP_W(2), .MAP_H(2)) u_dut2 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_last(out_last[1]), .frame_done(frame_done[1]), .busy(busy[1])
  );

  pool2x2_stream_ctrl u_dut24 (
    .clk(clk), .rst(rst[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_last(out_last[2]), .frame_done(frame_done[2]), .busy(busy[2])
  );

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [15:0] ta;
    logic [15:0] tb;
    logic [15:0] ba;
    logic [15:0] bb;
    logic [15:0] exp;
  } vec_t;

  exp_t        sb_q [$];
  logic [15:0] pix [576];
  int passed = 0;
  int total = 0;
  int cur = 0;
  int cyc = 0;
  int fd_cnt = 0;
  int last_cnt = 0;
  int irdy_low = 0;
  int last_out_cyc = 0;
  int first_acc_cyc = 0;
  logic fd_exp = 1'b0;
  logic stop_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [15:0] fp_max(input logic [15:0] x, input logic [15:0] y);
    logic x_gt;
    if (x[15] != y[15]) x_gt = y[15];
    else if (!x[15]) x_gt = (x[14:0] > y[14:0]);
    else x_gt = (x[14:0] < y[14:0]);
    return x_gt ? x : y;
  endfunction

  // Output monitor and scoreboard; samples on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (cur == 2 && !in_ready[2]) irdy_low++;
    if (frame_done[cur] || fd_exp) check("frame_done", 32'(frame_done[cur]), 32'(fd_exp));
    if (frame_done[cur]) fd_cnt++;
    fd_exp = out_valid[cur] && out_ready[cur] && out_last[cur];
    if (out_valid[cur] && out_ready[cur]) begin
      if (sb_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_output: got %0h expected none", out_data[cur]);
      end else begin
        e = sb_q.pop_front();
        check("out_data", 32'(out_data[cur]), 32'(e.data));
        check("out_last", 32'(out_last[cur]), 32'(e.last));
      end
      if (out_last[cur]) begin
        last_cnt++;
        last_out_cyc = cyc;
      end
    end
  end

  task automatic send(input int d, input logic [15:0] a, input logic [15:0] b);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    in_valid[d] = 1'b1;
    in_a[d] = a;
    in_b[d] = b;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_ready[d];
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      total++;
      $display("FAIL send_timeout: got in_ready=0 expected accept within 100 cycles");
    end
  endtask

  task automatic idle(input int d, input int n);
    in_valid[d] = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives a frame from pix; expected window max is pushed as its bottom pairs are driven.
  task automatic run_frame(input int d, input int w, input int h, input bit gaps, input int max_beats);
    exp_t e;
    int beats;
    beats = 0;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c += 2) begin
        if (beats >= max_beats) begin
          in_valid[d] = 1'b0;
          return;
        end
        if (gaps && $urandom_range(0, 3) == 0) idle(d, $urandom_range(1, 3));
        if (r % 2 == 1) begin
          e.data = fp_max(fp_max(pix[(r-1)*w+c], pix[(r-1)*w+c+1]),
                          fp_max(pix[r*w+c], pix[r*w+c+1]));
          e.last = (r == h - 1) && (c == w - 2);
          sb_q.push_back(e);
        end
        send(d, pix[r*w+c], pix[r*w+c+1]);
        if (beats == 0) first_acc_cyc = cyc;
        beats++;
      end
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain", 32'(sb_q.size()), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_ramp();
    logic [15:0] ramp [16];
    ramp = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800,
             16'h4880, 16'h4900, 16'h4980, 16'h4A00, 16'h4A80, 16'h4B00, 16'h4B80, 16'h4C00};
    for (int i = 0; i < 16; i++) pix[i] = ramp[i];
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) pix[i] = 16'($urandom());
  endtask

  vec_t vecs [6];
  int   fd_base;
  int   n_wait;

  initial begin
    vecs[0] = '{16'hBC00, 16'hC000, 16'hC200, 16'hB800, 16'hB800};
    vecs[1] = '{16'h4400, 16'h3C00, 16'h4000, 16'hBC00, 16'h4400};
    vecs[2] = '{16'h3C00, 16'h4500, 16'h4000, 16'h4200, 16'h4500};
    vecs[3] = '{16'h3C00, 16'h4000, 16'h4600, 16'h4200, 16'h4600};
    vecs[4] = '{16'hBC00, 16'hC000, 16'hC200, 16'h3800, 16'h3800};
    vecs[5] = '{16'h8000, 16'h8000, 16'h8000, 16'h0000, 16'h0000};

    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1;
      in_valid[d] = 1'b0;
      in_a[d] = 16'h0;
      in_b[d] = 16'h0;
      out_ready[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      check("rst_out_valid", 32'(out_valid[d]), 32'd0);
      check("rst_in_ready", 32'(in_ready[d]), 32'd1);
      check("rst_busy", 32'(busy[d]), 32'd0);
      check("rst_out_data", 32'(out_data[d]), 32'd0);
      check("rst_out_last", 32'(out_last[d]), 32'd0);
      check("rst_frame_done", 32'(frame_done[d]), 32'd0);
    end

    // 2x2 map: each window is a whole frame.
    cur = 1;
    fd_base = fd_cnt;
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back('{data: vecs[i].exp, last: 1'b1});
      send(1, vecs[i].ta, vecs[i].tb);
      send(1, vecs[i].ba, vecs[i].bb);
    end
    in_valid[1] = 1'b0;
    wait_drain();
    check("t2_frame_done_count", 32'(fd_cnt - fd_base), 32'd6);

    // 4x4 ramp frame, no backpressure.
    cur = 0;
    fill_ramp();
    fd_base = fd_cnt;
    run_frame(0, 4, 4, 1'b0, 1000);
    wait_drain();
    check("t1_frame_done_count", 32'(fd_cnt - fd_base), 32'd1);

    // 4x4 ramp frame with a 10-cycle output stall after the first result.
    out_ready[0] = 1'b0;
    fork
      run_frame(0, 4, 4, 1'b0, 1000);
      begin
        n_wait = 0;
        @(negedge clk);
        while (!out_valid[0] && n_wait < 100) begin
          @(negedge clk);
          n_wait++;
        end
        for (int i = 0; i < 10; i++) begin
          if (i > 0) @(negedge clk);
          check("t3_stall_valid", 32'(out_valid[0]), 32'd1);
          check("t3_stall_data", 32'(out_data[0]), 32'h4600);
        end
        check("t3_stall_in_ready", 32'(in_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
      end
    join
    wait_drain();

    // Reset after 5 accepted beats, then a fresh full frame.
    run_frame(0, 4, 4, 1'b0, 5);
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    rst[0] = 1'b0;
    check("t5_out_valid", 32'(out_valid[0]), 32'd0);
    check("t5_in_ready", 32'(in_ready[0]), 32'd1);
    check("t5_busy", 32'(busy[0]), 32'd0);
    check("t5_partial_drained", 32'(sb_q.size()), 32'd0);
    run_frame(0, 4, 4, 1'b0, 1000);
    wait_drain();

    // 24x24 random frame, continuous streaming.
    cur = 2;
    fill_random(576);
    irdy_low = 0;
    last_cnt = 0;
    run_frame(2, 24, 24, 1'b0, 1000);
    wait_drain();
    check("t4_last_count", 32'(last_cnt), 32'd1);
    check("t4_frame_cycles", 32'(last_out_cyc - first_acc_cyc + 1), 32'd432);
    check("t4_in_ready_low", 32'(irdy_low), 32'd144);

    // Two 4x4 random frames with input gaps and random backpressure.
    cur = 0;
    last_cnt = 0;
    fd_base = fd_cnt;
    stop_rdy = 1'b0;
    fork
      begin
        fill_random(16);
        run_frame(0, 4, 4, 1'b1, 1000);
        fill_random(16);
        run_frame(0, 4, 4, 1'b1, 1000);
        wait_drain();
        stop_rdy = 1'b1;
      end
      begin
        while (!stop_rdy) begin
          @(posedge clk);
          #1;
          out_ready[0] = 1'($urandom_range(0, 1));
        end
        out_ready[0] = 1'b1;
      end
    join
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("t6_last_count", 32'(last_cnt), 32'd2);
    check("t6_frame_done_count", 32'(fd_cnt - fd_base), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
